// File: rtl/imem_loader_if.sv
// Loader bus: start/count request, byte stream handshake, imem write port and core status.
// The loader uses the slave modport; whoever drives the byte stream uses master.
interface imem_loader_if #(
    parameter int ADDR_W = 9
);
    logic              start;
    logic [ADDR_W:0]   num_words;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_run;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, num_words, byte_in, byte_valid,
        input  byte_ready, imem_we, imem_addr, imem_wdata, cpu_run, busy, done, err
    );

    modport slave (
        input  start, num_words, byte_in, byte_valid,
        output byte_ready, imem_we, imem_addr, imem_wdata, cpu_run, busy, done, err
    );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: packs a byte stream MSB-first into 32-bit words and writes them to imem from address 0.
// Latency: imem_we pulses the cycle after the 4th byte of a word is accepted (>= 5 cycles per word).
// Backpressure: byte_ready is high only in LOAD; bytes offered in any other state wait or are ignored.
module imem_loader #(
    parameter int DEPTH          = 512,
    parameter int ADDR_W         = 9,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic         clk,
    input  logic         rst_n,
    imem_loader_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;
    logic              cpu_run_q, cpu_run_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic byte_acc;
    logic nw_ok;

    assign byte_acc = bus.byte_valid && (state_q == S_LOAD);
    assign nw_ok    = (bus.num_words != '0) && (bus.num_words <= (ADDR_W+1)'(DEPTH));

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        word_cnt_d   = word_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        timer_d      = timer_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        cpu_run_d    = cpu_run_q;
        done_d       = done_q;
        err_d        = err_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                // A rejected start leaves the core and done flag exactly as they were.
                if (bus.start) begin
                    if (!nw_ok) begin
                        err_d = 1'b1;
                    end else begin
                        count_d    = bus.num_words;
                        word_cnt_d = '0;
                        byte_cnt_d = '0;
                        timer_d    = '0;
                        err_d      = 1'b0;
                        done_d     = 1'b0;
                        cpu_run_d  = 1'b0;
                        state_d    = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (byte_acc) begin
                    imem_wdata_d = {imem_wdata_q[23:0], bus.byte_in};
                    byte_cnt_d   = byte_cnt_q + 2'd1;
                    timer_d      = '0;
                    if (byte_cnt_q == 2'd3) begin
                        imem_we_d   = 1'b1;
                        imem_addr_d = word_cnt_q;
                        state_d     = S_WRITE;
                    end
                end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_WRITE: begin
                if ({1'b0, word_cnt_q} == count_q - (ADDR_W+1)'(1)) begin
                    cpu_run_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    word_cnt_d = word_cnt_q + ADDR_W'(1);
                    state_d    = S_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_LOAD) || (state_d == S_WRITE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            word_cnt_q   <= '0;
            byte_cnt_q   <= '0;
            timer_q      <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_run_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            word_cnt_q   <= word_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            timer_q      <= timer_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_run_q    <= cpu_run_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign bus.byte_ready = (state_q == S_LOAD);
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign bus.cpu_run    = cpu_run_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: vector table for start handling, reference word model for loads,
// and hand-written sequences for timeout, reload from DONE and asynchronous reset.
module tb_imem_loader;
    localparam int DEPTH   = 512;
    localparam int ADDR_W  = 9;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(
        .DEPTH(DEPTH),
        .ADDR_W(ADDR_W),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int writes_seen = 0;
    logic prev_we = 1'b0;
    logic [7:0]  tx_q[$];
    logic [40:0] exp_q[$];

    typedef struct {
        logic [ADDR_W:0] nw;
        logic            exp_err;
        logic            exp_busy;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Write monitor: every imem_we must be a single-cycle pulse matching the next expected word.
    always @(negedge clk) begin
        if (bus.imem_we) begin
            writes_seen++;
            check("we_single_cycle", 64'(prev_we), 64'(0));
            check("write_expected", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0)
                check("write_addr_data", 64'({bus.imem_addr, bus.imem_wdata}), 64'(exp_q.pop_front()));
        end
        prev_we <= bus.imem_we;
    end

    task automatic pulse_start(input int n);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.num_words = (ADDR_W+1)'(n);
        @(negedge clk);
        bus.start     = 1'b0;
    endtask

    task automatic send_bytes(input int gap_pct);
        int guard = 0;
        while (tx_q.size() > 0 && guard < 60) begin
            @(negedge clk);
            if ($urandom_range(99) < gap_pct) begin
                bus.byte_valid = 1'b0;
                bus.byte_in    = 8'($urandom);
                guard++;
            end else begin
                bus.byte_valid = 1'b1;
                bus.byte_in    = tx_q[0];
                if (bus.byte_ready) begin
                    void'(tx_q.pop_front());
                    guard = 0;
                end else begin
                    guard++;
                end
            end
        end
        check("stream_drained", 64'(tx_q.size()), 64'(0));
        tx_q.delete();
        @(posedge clk);
        #1 bus.byte_valid = 1'b0;
    endtask

    task automatic fill_random(input int n);
        tx_q.delete();
        for (int i = 0; i < 4 * n; i++) tx_q.push_back(8'($urandom));
    endtask

    task automatic run_load(input int n, input int gap_pct, input bit poke);
        int w0;
        int k;
        w0 = writes_seen;
        for (int i = 0; i < n; i++)
            exp_q.push_back({ADDR_W'(i), tx_q[4*i], tx_q[4*i+1], tx_q[4*i+2], tx_q[4*i+3]});
        pulse_start(n);
        check("load_busy", 64'(bus.busy), 64'(1));
        check("load_cpu_held", 64'(bus.cpu_run), 64'(0));
        check("load_done_clr", 64'(bus.done), 64'(0));
        check("load_err_clr", 64'(bus.err), 64'(0));
        check("load_ready", 64'(bus.byte_ready), 64'(1));
        if (poke) begin
            pulse_start(3);
            check("start_in_load_busy", 64'(bus.busy), 64'(1));
            check("start_in_load_err", 64'(bus.err), 64'(0));
        end
        send_bytes(gap_pct);
        k = 0;
        @(negedge clk);
        while (!bus.done && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("load_done", 64'(bus.done), 64'(1));
        check("load_cpu_run", 64'(bus.cpu_run), 64'(1));
        check("load_busy_end", 64'(bus.busy), 64'(0));
        check("load_ready_end", 64'(bus.byte_ready), 64'(0));
        check("load_write_count", 64'(writes_seen - w0), 64'(n));
        check("load_all_written", 64'(exp_q.size()), 64'(0));
        exp_q.delete();
    endtask

    initial begin
        vec_t vecs[5];
        vecs[0] = '{nw: 10'd0,    exp_err: 1'b1, exp_busy: 1'b0};
        vecs[1] = '{nw: 10'd513,  exp_err: 1'b1, exp_busy: 1'b0};
        vecs[2] = '{nw: 10'd1023, exp_err: 1'b1, exp_busy: 1'b0};
        vecs[3] = '{nw: 10'd512,  exp_err: 1'b0, exp_busy: 1'b1};
        vecs[4] = '{nw: 10'd1,    exp_err: 1'b0, exp_busy: 1'b1};

        bus.start = 1'b0;
        bus.num_words = '0;
        bus.byte_in = '0;
        bus.byte_valid = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({bus.imem_we, bus.imem_addr, bus.imem_wdata, bus.cpu_run,
                                    bus.busy, bus.done, bus.err, bus.byte_ready}), 64'(0));
        rst_n = 1'b1;

        // Start handling from IDLE; accepted starts with no bytes then time out.
        for (int i = 0; i < 5; i++) begin
            int k;
            pulse_start(int'(vecs[i].nw));
            check($sformatf("vec%0d_err", i), 64'(bus.err), 64'(vecs[i].exp_err));
            check($sformatf("vec%0d_busy", i), 64'(bus.busy), 64'(vecs[i].exp_busy));
            check($sformatf("vec%0d_cpu_run", i), 64'(bus.cpu_run), 64'(0));
            if (vecs[i].exp_busy) begin
                k = 0;
                while (bus.busy && k < 40) begin
                    @(negedge clk);
                    k++;
                end
                check($sformatf("vec%0d_timeout_err", i), 64'(bus.err), 64'(1));
                check($sformatf("vec%0d_timeout_idle", i), 64'(bus.busy), 64'(0));
            end
        end
        check("no_write_from_starts", 64'(writes_seen), 64'(0));

        tx_q = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_load(2, 0, 1'b0);

        pulse_start(0);
        check("done_bad_start_err", 64'(bus.err), 64'(1));
        check("done_bad_start_cpu", 64'(bus.cpu_run), 64'(1));
        check("done_bad_start_done", 64'(bus.done), 64'(1));
        check("done_bad_start_busy", 64'(bus.busy), 64'(0));

        fill_random(1);
        run_load(1, 0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            int n;
            n = $urandom_range(1, 6);
            fill_random(n);
            run_load(n, 35, 1'b0);
        end

        // Timeout: two bytes, then silence for TIMEOUT idle cycles.
        begin
            int w0;
            w0 = writes_seen;
            tx_q = '{8'hA1, 8'hA2};
            pulse_start(1);
            send_bytes(0);
            @(negedge clk);
            repeat (TIMEOUT - 1) @(negedge clk);
            check("timeout_not_yet_busy", 64'(bus.busy), 64'(1));
            check("timeout_not_yet_err", 64'(bus.err), 64'(0));
            @(negedge clk);
            check("timeout_err", 64'(bus.err), 64'(1));
            check("timeout_busy", 64'(bus.busy), 64'(0));
            check("timeout_cpu_held", 64'(bus.cpu_run), 64'(0));
            check("timeout_no_write", 64'(writes_seen - w0), 64'(0));
        end

        fill_random(DEPTH);
        run_load(DEPTH, 20, 1'b1);

        // Asynchronous reset in the middle of a word.
        tx_q = '{8'h01, 8'h02};
        pulse_start(2);
        send_bytes(0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset_outputs", 64'({bus.imem_we, bus.imem_addr, bus.imem_wdata, bus.cpu_run,
                                             bus.busy, bus.done, bus.err, bus.byte_ready}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("after_reset_idle", 64'({bus.busy, bus.byte_ready, bus.imem_we}), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader for the 512 x 32 instruction memory.
- Accepts a byte stream (e.g. from a UART receiver) over a valid/ready handshake and packs bytes MSB-first into 32-bit words.
- Drives the memory's synchronous write port, one write per word, at consecutive addresses from 0.
- Holds the processor core stopped while loading. Releases it when the requested word count has been written.

Parameters:
- DEPTH, 512, instruction memory depth in words; legal num_words range is 1..DEPTH.
- ADDR_W, 9, width of imem_addr; DEPTH <= 2**ADDR_W.
- TIMEOUT_CYCLES, 1000000, idle LOAD cycles without an accepted byte before the load aborts.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin a load.
- num_words  in  ADDR_W+1  number of words to load; sampled only on an accepted start.
- byte_in  in  8  stream byte.
- byte_valid  in  1  byte_in valid.
- byte_ready  out  1  loader can accept a byte this cycle.
- imem_we  out  1  write enable to the instruction memory write port.
- imem_addr  out  ADDR_W  write address.
- imem_wdata  out  32  write data.
- cpu_run  out  1  1 = core may fetch/execute; 0 = core held stopped.
- busy  out  1  load in progress (LOAD or WRITE state).
- done  out  1  last load completed successfully.
- err  out  1  last start was rejected or the last load timed out; sticky until the next accepted start.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE; imem_we, byte_ready, cpu_run, busy, done and err = 0; imem_addr and imem_wdata = 0; all counters = 0.
- Registered outputs: all outputs are registered except byte_ready. byte_ready is decoded from state: 1 in LOAD only.
- Byte acceptance: a byte is accepted on a rising edge where byte_valid && byte_ready.
- States: IDLE, LOAD, WRITE, DONE.
- IDLE, start with num_words==0 or num_words>DEPTH: err<=1, stay IDLE.
- IDLE, start with 1 <= num_words <= DEPTH:
  - Latch count; word_cnt<=0; byte_cnt<=0; timer<=0.
  - err<=0, done<=0; go to LOAD.
- LOAD, per accepted byte:
  - imem_wdata <= {imem_wdata[23:0], byte_in}; byte_cnt++ (2 bits, wraps); timer<=0.
  - On the 4th byte (byte_cnt==3): imem_we<=1, imem_addr<=word_cnt; go to WRITE.
- LOAD, no byte accepted: timer++. When timer reaches TIMEOUT_CYCLES-1:
  - err<=1, imem_we stays 0, go to IDLE.
  - Words already written remain in memory; cpu_run stays 0.
- WRITE (exactly 1 cycle; imem_we=1, byte_ready=0): imem_we<=0 on exit.
  - If word_cnt==count-1: go to DONE, cpu_run<=1, done<=1.
  - Else: word_cnt++, go to LOAD.
- Write latency: imem_we rises in the cycle after the 4th byte is accepted. Minimum of 5 cycles per word.
- DONE: cpu_run=1, done=1, busy=0, byte_ready=0. Incoming bytes are not accepted.
- DONE, start:
  - Valid num_words: cpu_run<=0, done<=0, then as from IDLE.
  - Invalid num_words: err<=1, stay in DONE; cpu_run is unaffected.
- start in LOAD or WRITE: ignored (no restart, no err).
- busy = 1 in LOAD and WRITE, else 0.
- rst_n asserted mid-load: immediate return to IDLE with reset values. Memory contents are not cleared. The partial word is discarded.
- num_words==DEPTH: last write goes to address DEPTH-1; word_cnt never wraps.

Test Plan:
- Reset, then start num_words=2, bytes 12 34 56 78 AA BB CC DD back-to-back -> two single-cycle imem_we pulses: addr 0 data 0x12345678, addr 1 data 0xAABBCCDD; then cpu_run=1, done=1, busy=0.
- Byte stream with byte_valid gaps and byte_ready=0 during WRITE -> no byte lost or duplicated; the byte presented during the WRITE cycle is accepted in the following LOAD cycle.
- start num_words=0, then start num_words=513 -> err=1, state stays IDLE, no imem_we, cpu_run=0.
- TIMEOUT_CYCLES=16; start num_words=1, send 2 bytes then stop -> after 16 idle cycles err=1, busy=0, no imem_we, cpu_run=0.
- num_words=512 full load -> 512 writes at addresses 0..511, last at 511; done=1; a start pulse during LOAD is ignored.
- In DONE, start num_words=1 -> cpu_run drops the next cycle and a reload proceeds. rst_n pulsed low mid-word -> all outputs return to reset values asynchronously.
